// File: rtl/counter_cascade_pkg.sv
// Shared constants and helpers for the cascaded modulo counter.
package counter_cascade_pkg;

  localparam int unsigned DEF_STAGES   = 4;
  localparam int unsigned DEF_BIT      = 4;
  localparam int unsigned DEF_BASE     = 10;
  localparam int unsigned DEF_TOP_BASE = 10;

  // Modulus of stage i: the most significant stage may use a different base.
  function automatic int unsigned base_of(input int unsigned i,
                                          input int unsigned stages,
                                          input int unsigned base,
                                          input int unsigned top_base);
    return (i == stages - 1) ? top_base : base;
  endfunction

  // LSB position of stage i inside a packed digit vector.
  function automatic int unsigned digit_lsb(input int unsigned i,
                                            input int unsigned bits);
    return i * bits;
  endfunction

endpackage

// File: rtl/counter_cascade_stage.sv
// One modulo-base digit of the cascade: registered digit plus combinational terminal flag.
module counter_cascade_stage
  import counter_cascade_pkg::*;
#(
  parameter int unsigned P_BIT = DEF_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_in,
  input  logic             up_dw,
  input  logic             clear,
  input  logic             load,
  input  logic [P_BIT-1:0] load_digit,
  input  logic [P_BIT:0]   base,
  output logic [P_BIT-1:0] digit,
  output logic             terminal
);

  localparam int unsigned BASE_W = P_BIT + 1;

  logic [P_BIT-1:0] digit_q;
  logic [P_BIT-1:0] digit_d;
  logic [P_BIT-1:0] max_digit;

  assign max_digit = P_BIT'(base - BASE_W'(1));

  // Out-of-range loaded digits count as terminal when going up so they wrap to 0.
  assign terminal = up_dw ? (digit_q >= max_digit) : (digit_q == '0);

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = load_digit;
    end else if (step_in) begin
      if (up_dw) begin
        digit_d = terminal ? '0 : digit_q + P_BIT'(1);
      end else begin
        digit_d = terminal ? max_digit : digit_q - P_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/counter_cascade.sv
// Multi-digit cascaded modulo up/down counter with clear, parallel load and wrap strobes.
// Define COUNTER_CASCADE_SAT_EN to hold the count at its limit instead of wrapping.
module counter_cascade
  import counter_cascade_pkg::*;
#(
  parameter int unsigned P_STAGES   = DEF_STAGES,
  parameter int unsigned P_BIT      = DEF_BIT,
  parameter int unsigned P_BASE     = DEF_BASE,
  parameter int unsigned P_TOP_BASE = DEF_TOP_BASE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      up_dw,
  input  logic                      clear,
  input  logic                      load,
  input  logic [P_STAGES*P_BIT-1:0] load_value,
  output logic [P_STAGES*P_BIT-1:0] count,
  output logic [P_STAGES-1:0]       stage_carry,
  output logic                      carry
);

  localparam int unsigned BASE_W = P_BIT + 1;

  logic [P_STAGES-1:0] term;
  logic [P_STAGES-1:0] step;
  logic                hold;

`ifdef COUNTER_CASCADE_SAT_EN
  // Every stage would wrap this cycle: freeze the count, keep the strobes.
  assign hold = enable & (&term);
`else
  assign hold = 1'b0;
`endif

  for (genvar i = 0; i < P_STAGES; i++) begin : g_stage
    localparam logic [P_STAGES-1:0] LOW_MASK = P_STAGES'((64'd1 << i) - 64'd1);
    localparam int unsigned         LSB      = digit_lsb(i, P_BIT);

    // Stage i steps when every lower stage is terminal (mask selects stages 0..i-1).
    assign step[i] = enable & (&(term | ~LOW_MASK));

    assign stage_carry[i] = step[i] & term[i] & ~clear & ~load & ~reset;

    counter_cascade_stage #(
      .P_BIT (P_BIT)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .step_in    (step[i] & ~hold),
      .up_dw      (up_dw),
      .clear      (clear),
      .load       (load),
      .load_digit (load_value[LSB +: P_BIT]),
      .base       (BASE_W'(base_of(i, P_STAGES, P_BASE, P_TOP_BASE))),
      .digit      (count[LSB +: P_BIT]),
      .terminal   (term[i])
    );
  end

  assign carry = stage_carry[P_STAGES-1];

endmodule

// File: tb/tb_counter_cascade.sv
// Scoreboard bench for counter_cascade configured as a 00..59 counter.
module tb_counter_cascade;

  localparam int unsigned N    = 2;
  localparam int unsigned B    = 4;
  localparam int unsigned BASE = 10;
  localparam int unsigned TOP  = 6;
  localparam int unsigned W    = N * B;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         up_dw;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic [N-1:0] stage_carry;
  logic         carry;

  typedef struct {
    logic [W-1:0] cnt;
    logic [N-1:0] sc;
  } exp_t;

  exp_t         sb_q[$];
  int           passed = 0;
  int           total  = 0;
  logic [W-1:0] mcount;

  always #5 clk = ~clk;

  counter_cascade #(
    .P_STAGES   (N),
    .P_BIT      (B),
    .P_BASE     (BASE),
    .P_TOP_BASE (TOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .up_dw       (up_dw),
    .clear       (clear),
    .load        (load),
    .load_value  (load_value),
    .count       (count),
    .stage_carry (stage_carry),
    .carry       (carry)
  );

  // Reference: digit list, odometer rules applied least significant digit first.
  function automatic void model_step(input logic [W-1:0] cur, input logic en, input logic up,
                                     input logic clr, input logic ld, input logic [W-1:0] lv,
                                     output logic [W-1:0] nxt, output logic [N-1:0] sc);
    int d;
    int b;
    bit lim;
    bit go;
    sc  = '0;
    nxt = cur;
    go  = en;
    if (clr) begin
      nxt = '0;
    end else if (ld) begin
      nxt = lv;
    end else begin
      for (int i = 0; i < N; i++) begin
        d   = int'(cur[i*B +: B]);
        b   = (i == N - 1) ? int'(TOP) : int'(BASE);
        lim = up ? (d >= b - 1) : (d == 0);
        if (go) begin
          if (up) d = lim ? 0 : d + 1;
          else    d = lim ? b - 1 : d - 1;
          sc[i] = lim;
        end
        nxt[i*B +: B] = B'(d);
        go = go & lim;
      end
`ifdef COUNTER_CASCADE_SAT_EN
      if (go) nxt = cur;
`endif
    end
  endfunction

  task automatic drive(input logic rst, input logic en, input logic up, input logic clr,
                       input logic ld, input logic [W-1:0] lv);
    exp_t         e;
    logic [W-1:0] nxt;
    logic [N-1:0] sc;
    @(posedge clk);
    #1;
    reset      = rst;
    enable     = en;
    up_dw      = up;
    clear      = clr;
    load       = ld;
    load_value = lv;
    if (rst) begin
      mcount = '0;
      e.cnt  = '0;
      e.sc   = '0;
    end else begin
      model_step(mcount, en, up, clr, ld, lv, nxt, sc);
      e.cnt  = mcount;
      e.sc   = sc;
      mcount = nxt;
    end
    sb_q.push_back(e);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("count", 32'(count), 32'(e.cnt));
      check("stage_carry", 32'(stage_carry), 32'(e.sc));
      check("carry", 32'(carry), 32'(e.sc[N-1]));
    end
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    up_dw      = 1'b1;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = '0;
    mcount     = '0;

    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    // Full up sweep through 59 and past the wrap.
    repeat (61) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);

    do_load(8'h10);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    do_load(8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

    do_load(8'h37);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h45);
    do_load(8'hF9);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);

    do_load(8'h09);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    do_load(8'h19);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

    do_load(8'h42);
    repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);

    // Limit behaviour: wraps by default, holds in saturating builds.
    do_load(8'h59);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    do_load(8'h00);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

    repeat (600) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), W'($urandom));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    for (int k = 0; k < 8 && sb_q.size() != 0; k++) @(negedge clk);
    if (sb_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
